// File: rtl/dvi_pattern_pkg.sv
// Shared definitions for the 720p test-pattern source: pattern indices,
// 24-bit colour constants, the colour-bar table and the box bounce rule.
package dvi_pattern_pkg;

  localparam logic [2:0] PAT_BARS       = 3'd0;
  localparam logic [2:0] PAT_GRADIENT   = 3'd1;
  localparam logic [2:0] PAT_CROSSHATCH = 3'd2;
  localparam logic [2:0] PAT_CHECKER    = 3'd3;
  localparam logic [2:0] PAT_BOX        = 3'd4;
  localparam logic [2:0] PAT_WHITE      = 3'd5;
  localparam logic [2:0] PAT_BLACK      = 3'd6;
  localparam logic [2:0] PAT_GREY       = 3'd7;

  typedef logic [23:0] rgb_t;

  localparam rgb_t WHITE     = 24'hFFFFFF;
  localparam rgb_t YELLOW    = 24'hFFFF00;
  localparam rgb_t CYAN      = 24'h00FFFF;
  localparam rgb_t GREEN     = 24'h00FF00;
  localparam rgb_t MAGENTA   = 24'hFF00FF;
  localparam rgb_t RED       = 24'hFF0000;
  localparam rgb_t BLUE      = 24'h0000FF;
  localparam rgb_t BLACK     = 24'h000000;
  localparam rgb_t GREY50    = 24'h808080;
  localparam rgb_t DARK_GREY = 24'h202020;

  // Left-to-right bar order across the active line.
  localparam rgb_t BAR_COLOURS [8] = '{WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK};

  typedef enum logic {DIR_POS, DIR_NEG} dir_t;

  typedef struct packed {
    logic [11:0] pos;
    dir_t        dir;
  } axis_t;

  // One frame of bounce motion along a single axis, clamped to [0, maxPos].
  function automatic axis_t bounceStep(input logic [11:0] pos, input dir_t dir,
                                       input logic [11:0] maxPos, input logic [11:0] step);
    axis_t result;
    result.pos = pos;
    result.dir = dir;
    if (dir == DIR_POS) begin
      if (pos + step >= maxPos) begin
        result.pos = maxPos;
        result.dir = DIR_NEG;
      end else begin
        result.pos = pos + step;
      end
    end else begin
      if (pos <= step) begin
        result.pos = '0;
        result.dir = DIR_POS;
      end else begin
        result.pos = pos - step;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/dvi_box_animator.sv
// Moving-box position generator: advances the box one step per frame and
// reverses direction independently on each axis at the active-area edges.
module dvi_box_animator #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2
) (
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic        frameStart,
  output logic [11:0] boxX,
  output logic [11:0] boxY
);
  import dvi_pattern_pkg::*;

  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] STEP  = 12'(BOX_STEP);

  dir_t  dirX, dirY;
  axis_t nextX, nextY;

  // Position and direction registers; box starts at the origin heading +X/+Y.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      boxX <= '0;
      boxY <= '0;
      dirX <= DIR_POS;
      dirY <= DIR_POS;
    end else begin
      boxX <= nextX.pos;
      boxY <= nextY.pos;
      dirX <= nextX.dir;
      dirY <= nextY.dir;
    end
  end

  // Next-state: hold between frames, take one bounce step on each frameStart.
  // NOTE: hold values are assigned first so no path leaves a latch behind.
  always_comb begin
    nextX = '{pos: boxX, dir: dirX};
    nextY = '{pos: boxY, dir: dirY};
    if (frameStart) begin
      nextX = bounceStep(boxX, dirX, X_MAX, STEP);
      nextY = bounceStep(boxY, dirY, Y_MAX, STEP);
    end
  end

endmodule

// File: rtl/dvi_test_pattern_source.sv
// Selectable 720p test-pattern source feeding DviEncoder. Pattern changes
// take effect only on the vSync leading edge; RGB and sync outputs share a
// 2-cycle pipeline. Optional macro DVI_PATTERN_BORDER_EN overlays a 1-px
// white border on every pattern except solid black.
module dvi_test_pattern_source #(
  parameter int H_ACTIVE        = 1280,
  parameter int V_ACTIVE        = 720,
  parameter int BOX_SIZE        = 64,
  parameter int BOX_STEP        = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b0
) (
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic        dataEnable,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] hPos,
  input  logic [10:0] vPos,
  input  logic [2:0]  patternSelect,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        dataEnableOut,
  output logic        hSyncOut,
  output logic        vSyncOut,
  output logic [2:0]  activePattern
);
  import dvi_pattern_pkg::*;

  localparam int          BAR_WIDTH = H_ACTIVE / 8;
  localparam int          BAR_CNT_W = $clog2(BAR_WIDTH);
  localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic                 vSyncActive, vSyncActivePrev, frameStart;
  logic [BAR_CNT_W-1:0] barCount;
  logic [2:0]           barIndex;
  logic [11:0]          boxX, boxY, vPosWide;
  logic                 insideBox;
  rgb_t                 pixelColour;
  logic                 stageDe, stageHSync, stageVSync;
  rgb_t                 stageRgb, outRgb;

  assign vSyncActive = vSync ^ SYNC_ACTIVE_LOW;
  assign frameStart  = vSyncActive & ~vSyncActivePrev;
  assign vPosWide    = {1'b0, vPos};

  // vSync edge detect and frame-aligned pattern latch.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      vSyncActivePrev <= 1'b0;
      activePattern   <= PAT_BARS;
    end else begin
      vSyncActivePrev <= vSyncActive;
      if (frameStart) activePattern <= patternSelect;
    end
  end

  // Bar position counter; held at zero through blanking so the first pixel
  // after each dataEnable rise starts bar 0, and wraps every BAR_WIDTH pixels.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      barCount <= '0;
      barIndex <= '0;
    end else if (!dataEnable) begin
      barCount <= '0;
      barIndex <= '0;
    end else if (barCount == BAR_CNT_W'(BAR_WIDTH - 1)) begin
      barCount <= '0;
      barIndex <= barIndex + 3'd1;
    end else begin
      barCount <= barCount + 1'b1;
    end
  end

  dvi_box_animator #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) boxAnimator (
    .pixelClock (pixelClock),
    .resetN     (resetN),
    .frameStart (frameStart),
    .boxX       (boxX),
    .boxY       (boxY)
  );

  assign insideBox = (hPos >= boxX) && (hPos < boxX + 12'(BOX_SIZE)) &&
                     (vPosWide >= boxY) && (vPosWide < boxY + 12'(BOX_SIZE));

`ifdef DVI_PATTERN_BORDER_EN
  logic onBorder;
  assign onBorder = (hPos == 12'd0) || (hPos == 12'(H_ACTIVE - 1)) ||
                    (vPosWide == 12'd0) || (vPosWide == 12'(V_ACTIVE - 1));
`endif

  // Pattern mux for the pixel currently presented by the timing generator.
  always_comb begin
    pixelColour = BLACK;
    case (activePattern)
      PAT_BARS:       pixelColour = BAR_COLOURS[barIndex];
      PAT_GRADIENT:   pixelColour = {hPos[10:3], vPos[9:2], ~hPos[10:3]};
      PAT_CROSSHATCH: pixelColour = (hPos[5:0] == 6'd0 || vPos[5:0] == 6'd0) ? WHITE : BLACK;
      PAT_CHECKER:    pixelColour = (hPos[6] ^ vPos[6]) ? WHITE : BLACK;
      PAT_BOX:        pixelColour = insideBox ? WHITE : DARK_GREY;
      PAT_WHITE:      pixelColour = WHITE;
      PAT_BLACK:      pixelColour = BLACK;
      default:        pixelColour = GREY50;
    endcase
`ifdef DVI_PATTERN_BORDER_EN
    if (onBorder && activePattern != PAT_BLACK) pixelColour = WHITE;
`endif
  end

  // Two-stage pipeline keeping RGB and timing aligned; colour is blanked
  // whenever the accompanying dataEnable is low.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      stageDe       <= 1'b0;
      stageHSync    <= SYNC_IDLE;
      stageVSync    <= SYNC_IDLE;
      stageRgb      <= BLACK;
      dataEnableOut <= 1'b0;
      hSyncOut      <= SYNC_IDLE;
      vSyncOut      <= SYNC_IDLE;
      outRgb        <= BLACK;
    end else begin
      stageDe       <= dataEnable;
      stageHSync    <= hSync;
      stageVSync    <= vSync;
      stageRgb      <= dataEnable ? pixelColour : BLACK;
      dataEnableOut <= stageDe;
      hSyncOut      <= stageHSync;
      vSyncOut      <= stageVSync;
      outRgb        <= stageRgb;
    end
  end

  assign {red, green, blue} = outRgb;

endmodule

// File: tb/tb_dvi_test_pattern_source.sv
// Randomised self-checking bench for dvi_test_pattern_source with a
// frame-level reference model of patterns, bars and box motion.
module tb_dvi_test_pattern_source;

  logic        pixelClock = 1'b0;
  logic        resetN;
  logic        dataEnable, hSync, vSync;
  logic [11:0] hPos;
  logic [10:0] vPos;
  logic [2:0]  patternSelect;
  logic [7:0]  red, green, blue;
  logic        dataEnableOut, hSyncOut, vSyncOut;
  logic [2:0]  activePattern;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int          mPat, mBx, mBy, mDx, mDy, mBarPos;
  bit          mPrevVs, mPrevDe;
  logic [26:0] expQ[$];
  logic [23:0] barTable [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 pixelClock = ~pixelClock;

  dvi_test_pattern_source dut (
    .pixelClock    (pixelClock),
    .resetN        (resetN),
    .dataEnable    (dataEnable),
    .hSync         (hSync),
    .vSync         (vSync),
    .hPos          (hPos),
    .vPos          (vPos),
    .patternSelect (patternSelect),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .dataEnableOut (dataEnableOut),
    .hSyncOut      (hSyncOut),
    .vSyncOut      (vSyncOut),
    .activePattern (activePattern)
  );

  function automatic logic [23:0] modelColour(int pat, int h, int v, int pos, int bx, int by);
    logic [23:0] c;
    int r;
    case (pat)
      0: c = barTable[(pos / 160) % 8];
      1: begin
        r = (h / 8) % 256;
        c = {8'(r), 8'((v / 4) % 256), 8'(255 - r)};
      end
      2: c = (h % 64 == 0 || v % 64 == 0) ? 24'hFFFFFF : 24'h000000;
      3: c = (((h / 64) % 2) != ((v / 64) % 2)) ? 24'hFFFFFF : 24'h000000;
      4: c = (h >= bx && h < bx + 64 && v >= by && v < by + 64) ? 24'hFFFFFF : 24'h202020;
      5: c = 24'hFFFFFF;
      6: c = 24'h000000;
      default: c = 24'h808080;
    endcase
`ifdef DVI_PATTERN_BORDER_EN
    if (pat != 6 && (h == 0 || h == 1279 || v == 0 || v == 719)) c = 24'hFFFFFF;
`endif
    return c;
  endfunction

  function automatic void boxStep(inout int p, inout int d, input int lim);
    if (d > 0) begin
      if (p + 2 >= lim) begin p = lim; d = -1; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1; end
      else p = p - 2;
    end
  endfunction

  task automatic modelReset();
    mPat = 0; mBx = 0; mBy = 0; mDx = 1; mDy = 1; mBarPos = 0;
    mPrevVs = 1'b0; mPrevDe = 1'b0;
    expQ = {27'h0, 27'h0};
  endtask

  // One pixel clock: sample outputs due now, then present the next input set.
  task automatic advance(input bit de, input bit hs, input bit vs, input int h, input int v,
                         input logic [2:0] ps, output logic [26:0] obs, output logic [26:0] expd,
                         output logic [2:0] obsPat, output logic [2:0] expPat);
    logic [23:0] c;
    @(posedge pixelClock); #1;
    obs    = {dataEnableOut, hSyncOut, vSyncOut, red, green, blue};
    expd   = expQ.pop_front();
    obsPat = activePattern;
    expPat = 3'(mPat);
    dataEnable = de; hSync = hs; vSync = vs;
    hPos = 12'(h); vPos = 11'(v); patternSelect = ps;
    if (de) mBarPos = mPrevDe ? mBarPos + 1 : 0;
    mPrevDe = de;
    c = de ? modelColour(mPat, h, v, mBarPos, mBx, mBy) : 24'h0;
    expQ.push_back({de, hs, vs, c});
    if (vs && !mPrevVs) begin
      mPat = int'(ps);
      boxStep(mBx, mDx, 1216);
      boxStep(mBy, mDy, 656);
    end
    mPrevVs = vs;
  endtask

  // vSync pulse producing one frameStart; outputs in these cycles are not compared.
  task automatic frameEdge(input logic [2:0] ps);
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    advance(0, 0, 1, 0, 0, ps, o, e, op, ep);
    advance(0, 0, 1, 0, 0, ps, o, e, op, ep);
    advance(0, 0, 0, 0, 0, ps, o, e, op, ep);
    advance(0, 0, 0, 0, 0, ps, o, e, op, ep);
  endtask

  task automatic test_reset();
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    resetN = 1'b0;
    dataEnable = 0; hSync = 0; vSync = 0; hPos = '0; vPos = '0; patternSelect = 3'd5;
    #23;
    vectors++;
    if ({dataEnableOut, hSyncOut, vSyncOut, red, green, blue} !== 27'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", {dataEnableOut, hSyncOut, vSyncOut, red, green, blue}, 27'h0);
    end
    vectors++;
    if (activePattern !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_pattern: got %0d want 0", activePattern);
    end
    @(posedge pixelClock); #1;
    resetN = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      advance(0, 0, 0, 0, 0, 3'd5, o, e, op, ep);
      vectors++;
      if (o !== e || op !== ep) begin
        miscompares++;
        $display("FAIL reset_idle: got %h/%0d want %h/%0d", o, op, e, ep);
      end
    end
  endtask

  task automatic test_bars();
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    frameEdge(3'd0);
    for (int line = 0; line < 2; line++) begin
      for (int h = 0; h < (line == 0 ? 1280 : 400); h++) begin
        advance(1, 0, 0, h, line, 3'd0, o, e, op, ep);
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL bars line%0d px%0d: got %h want %h", line, h, o, e);
        end
      end
      for (int b = 0; b < 20; b++) begin
        advance(0, (b >= 4 && b < 10), 0, 0, 0, 3'd0, o, e, op, ep);
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL bars blank%0d: got %h want %h", b, o, e);
        end
      end
    end
  endtask

  task automatic test_box();
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    int px [6];
    int py [6];
    for (int f = 0; f < 700; f++) begin
      frameEdge(3'd4);
      px = '{mBx, mBx + 63, mBx + 64, (mBx > 0) ? mBx - 1 : mBx + 64, mBx, mBx};
      py = '{mBy, mBy + 63, mBy, mBy, mBy + 64, (mBy > 0) ? mBy - 1 : mBy + 64};
      for (int k = 0; k < 6; k++) begin
        advance(1, 0, 0, px[k], py[k], 3'd4, o, e, op, ep);
        vectors++;
        if (o !== e || op !== ep) begin
          miscompares++;
          $display("FAIL box frame%0d probe%0d: got %h/%0d want %h/%0d", f, k, o, op, e, ep);
        end
      end
      advance(0, 0, 0, 0, 0, 3'd4, o, e, op, ep);
    end
  endtask

  task automatic test_timing();
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    for (int i = 0; i < 800; i++) begin
      advance($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 4095), $urandom_range(0, 2047), 3'($urandom), o, e, op, ep);
      vectors++;
      if (o !== e || op !== ep) begin
        miscompares++;
        $display("FAIL timing cycle%0d: got %h/%0d want %h/%0d", i, o, op, e, ep);
      end
    end
  endtask

  task automatic test_pattern_switch();
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    frameEdge(3'd0);
    for (int h = 0; h < 128; h++) begin
      advance(1, 0, 0, h, 0, (h < 64) ? 3'd0 : 3'd2, o, e, op, ep);
      vectors++;
      if (o !== e || op !== ep) begin
        miscompares++;
        $display("FAIL switch_midframe px%0d: got %h/%0d want %h/%0d", h, o, op, e, ep);
      end
    end
    frameEdge(3'd2);
    for (int h = 0; h < 130; h++) begin
      advance((h < 128), 0, 0, h, 1, 3'd2, o, e, op, ep);
      vectors++;
      if (o !== e || op !== ep) begin
        miscompares++;
        $display("FAIL switch_newframe px%0d: got %h/%0d want %h/%0d", h, o, op, e, ep);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    frameEdge(3'd7);
    for (int h = 0; h < 200; h++) begin
      advance(1, 0, 0, h, 5, 3'd7, o, e, op, ep);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midline_pre px%0d: got %h want %h", h, o, e);
      end
    end
    #3 resetN = 1'b0;
    #1;
    vectors++;
    if ({dataEnableOut, hSyncOut, vSyncOut, red, green, blue} !== 27'h0 || activePattern !== 3'd0) begin
      miscompares++;
      $display("FAIL midline_async: got %h/%0d want 0/0", {dataEnableOut, hSyncOut, vSyncOut, red, green, blue}, activePattern);
    end
    @(posedge pixelClock);
    @(posedge pixelClock); #1;
    dataEnable = 0; hSync = 0; vSync = 0;
    resetN = 1'b1;
    modelReset();
    for (int h = 0; h < 1282; h++) begin
      advance((h < 1280), 0, 0, h, 0, 3'd3, o, e, op, ep);
      vectors++;
      if (o !== e || op !== ep) begin
        miscompares++;
        $display("FAIL midline_resume px%0d: got %h/%0d want %h/%0d", h, o, op, e, ep);
      end
    end
  endtask

  task automatic test_border();
    logic [26:0] o, e;
    logic [2:0]  op, ep;
    int bx [4] = '{0, 1279, 640, 1279};
    int by [4] = '{300, 719, 300, 0};
    for (int p = 0; p < 2; p++) begin
      frameEdge(p == 0 ? 3'd3 : 3'd6);
      for (int k = 0; k < 6; k++) begin
        advance((k < 4), 0, 0, (k < 4) ? bx[k] : 0, (k < 4) ? by[k] : 0, 3'd0, o, e, op, ep);
        vectors++;
        if (o !== e || op !== ep) begin
          miscompares++;
          $display("FAIL border pat%0d step%0d: got %h/%0d want %h/%0d", p == 0 ? 3 : 6, k, o, op, e, ep);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_box();
    test_timing();
    test_pattern_switch();
    test_reset_midline();
    test_border();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
